fetch_pc_gen: RTL and testbench
===============================

// Module: fetch_pc_gen
// PURPOSE
//   Instruction-fetch front end: owns the PC register, drives it to imem and the BTB,
//   and picks next PC from BTB hit + internal 2-bit bimodal counters, EX redirect or PC+4.
//   Holds the IF/ID prediction register consumed by decode.
//   Turns EX-stage branch resolution into BTB write commands and counter updates.
// PARAMETERS
//   PC_W      17  PC width in bits (byte address, low 2 bits always 0)
//   IDX_W     5   BTB/counter index width; index = pc[IDX_W+1:2], 2**IDX_W entries
//   RESET_PC  0   PC value loaded on reset
// PORTS
//   clk            in   1         clock, all state on posedge
//   rst            in   1         synchronous reset, active-high
//   stall          in   1         hazard stall: hold PC and IF/ID register
//   redirect       in   1         EX mispredict: load redirect_pc, squash IF/ID
//   redirect_pc    in   PC_W      correct next PC from EX
//   ex_valid       in   1         EX resolved a control-flow instruction this cycle
//   ex_pc          in   PC_W      PC of that instruction
//   ex_taken       in   1         resolved direction
//   ex_target      in   PC_W      resolved taken target
//   btb_hit        in   1         BTB lookup result for current pc (combinational)
//   pred_pc        in   PC_W      BTB target for current pc
//   pc             out  PC_W      current fetch PC, to imem and BTB
//   btb_we         out  1         BTB write enable (registered)
//   btb_waddr      out  IDX_W     BTB write index
//   btb_wd         out  PC_W+PC_W-IDX_W-1  {valid, tag=pc[PC_W-1:IDX_W+2], target}; 28 bits at defaults
//   if_valid       out  1         IF/ID entry valid
//   if_pc          out  PC_W      PC of IF/ID instruction
//   if_pred_taken  out  1         fetch predicted taken
//   if_pred_pc     out  PC_W      predicted next PC (pred_pc or pc+4)
// BEHAVIOUR
//   Reset: pc=RESET_PC; if_valid=0, if_pc=0, if_pred_taken=0, if_pred_pc=0; btb_we=0,
//     btb_waddr=0, btb_wd=0; all counters=2'b01 (weak not-taken). Reset beats every input.
//   Prediction (comb): pred_taken = btb_hit & ctr[pc idx][1]; seq = pc+4 mod 2**PC_W
//     (0x1FFFC -> 0x00000 at defaults); npred = pred_taken ? pred_pc : seq.
//   PC reg priority: rst > redirect (pc<=redirect_pc) > stall (hold) > pc<=npred.
//     Redirect overrides a simultaneous stall.
//   IF/ID reg: redirect -> if_valid<=0, other fields don't-care-held; else stall -> hold all;
//     else if_valid<=1, if_pc<=pc, if_pred_taken<=pred_taken, if_pred_pc<=npred.
//   Latency: instruction at pc appears on IF/ID one cycle later.
//   Counter update: on ex_valid, ctr[ex_pc idx] saturating +1 if ex_taken else -1 (0..3).
//     Independent of stall/redirect. Same-cycle read of the updated index sees old value.
//   BTB write: ex_valid & ex_taken -> next cycle btb_we=1, btb_waddr=ex_pc idx,
//     btb_wd={1'b1, ex_pc tag, ex_target}; btb_we high exactly one cycle per event,
//     back-to-back events give back-to-back writes. Not-taken never writes the BTB.
//   Reset mid-operation clears any pending btb_we that cycle; counters re-init.
// TESTING
//   1 rst=1 2 cycles then 0, no hits -> pc 0x0,0x4,0x8; if_pc lags pc by one cycle;
//     if_valid 0 during reset, 1 from first post-reset edge; btb_we=0 throughout.
//   2 pc=0x10, btb_hit=1, pred_pc=0x100, ctr=01 -> next pc 0x14, if_pred_taken=0;
//     two ex_valid/ex_taken at ex_pc=0x10 (ctr->11) -> next hit gives pc 0x100,
//     if_pred_taken=1, if_pred_pc=0x100; third taken update keeps ctr=11.
//   3 stall=1 3 cycles -> pc, if_* held; stall=1 & redirect=1, redirect_pc=0x200
//     -> pc=0x200, if_valid=0 next cycle, then fetch resumes 0x204.
//   4 ex_valid=1, ex_taken=1, ex_pc=0x1F4, ex_target=0x80 for one cycle -> next cycle
//     btb_we=1, btb_waddr=0x1D, btb_wd=0x8060080; following cycle btb_we=0.
//   5 ex_valid=1, ex_taken=0 at ex_pc=0x10 with ctr=00 -> ctr stays 00, btb_we stays 0.
//   6 pc=0x1FFFC, btb_hit=0 -> next pc 0x00000; rst asserted same cycle as
//     BTB-write event -> btb_we=0 next cycle, pc=RESET_PC.

Source files
------------

// File: rtl/fetch_pc_gen_if.sv
// Fetch front-end bus bundle.
// Groups the hazard/redirect controls, EX-stage branch resolution, BTB lookup/write
// and IF/ID prediction signals of fetch_pc_gen.
//   master : the fetch unit (drives pc, btb_we/btb_waddr/btb_wd, if_*)
//   slave  : the surrounding pipeline (drives stall, redirect*, ex_*, btb_hit, pred_pc)
interface fetch_pc_gen_if #(
   parameter int unsigned PC_W  = 17,
   parameter int unsigned IDX_W = 5
);
   localparam int unsigned WD_W = PC_W + PC_W - IDX_W - 1;

   // pipeline control
   logic              stall;
   logic              redirect;
   logic [PC_W-1:0]   redirect_pc;

   // EX-stage resolution
   logic              ex_valid;
   logic [PC_W-1:0]   ex_pc;
   logic              ex_taken;
   logic [PC_W-1:0]   ex_target;

   // BTB lookup for the current pc
   logic              btb_hit;
   logic [PC_W-1:0]   pred_pc;

   // fetch PC and BTB write port
   logic [PC_W-1:0]   pc;
   logic              btb_we;
   logic [IDX_W-1:0]  btb_waddr;
   logic [WD_W-1:0]   btb_wd;

   // IF/ID prediction register
   logic              if_valid;
   logic [PC_W-1:0]   if_pc;
   logic              if_pred_taken;
   logic [PC_W-1:0]   if_pred_pc;

   modport master (
      input  stall, redirect, redirect_pc,
      input  ex_valid, ex_pc, ex_taken, ex_target,
      input  btb_hit, pred_pc,
      output pc, btb_we, btb_waddr, btb_wd,
      output if_valid, if_pc, if_pred_taken, if_pred_pc
   );

   modport slave (
      output stall, redirect, redirect_pc,
      output ex_valid, ex_pc, ex_taken, ex_target,
      output btb_hit, pred_pc,
      input  pc, btb_we, btb_waddr, btb_wd,
      input  if_valid, if_pc, if_pred_taken, if_pred_pc
   );
endinterface

// File: rtl/fetch_pc_gen.sv
// Instruction-fetch PC generator.
// Owns the fetch PC, predicts the next PC from the BTB hit combined with a table of
// 2-bit bimodal counters (or falls through to pc+4), honours EX redirects and hazard
// stalls, holds the IF/ID prediction register, and turns EX branch resolutions into
// counter updates and registered BTB write commands.
// Ports:
//   clk  : clock, all state updates on posedge
//   rst  : synchronous active-high reset, dominates every other input
//   bus  : fetch_pc_gen_if.master (controls, EX resolution, BTB lookup/write, IF/ID)
module fetch_pc_gen #(
   parameter int unsigned     PC_W     = 17,
   parameter int unsigned     IDX_W    = 5,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic           clk,
   input  logic           rst,
   fetch_pc_gen_if.master bus
);
   localparam int unsigned N_ENT = 1 << IDX_W;
   localparam int unsigned TAG_W = PC_W - IDX_W - 2;
   localparam int unsigned WD_W  = 1 + TAG_W + PC_W;

   logic [1:0]       ctr_q [N_ENT];

   logic [IDX_W-1:0] fetch_idx_c;
   logic [IDX_W-1:0] ex_idx_c;
   logic             pred_taken_c;
   logic [PC_W-1:0]  seq_pc_c;
   logic [PC_W-1:0]  npred_c;
   logic [1:0]       ctr_nxt_c;
   logic             btb_evt_c;
   logic [TAG_W-1:0] ex_tag_c;
   logic             unused_ok_c;

   // Next-PC prediction and saturating counter update value
   always_comb begin
      fetch_idx_c  = bus.pc[IDX_W+1:2];
      ex_idx_c     = bus.ex_pc[IDX_W+1:2];
      ex_tag_c     = bus.ex_pc[PC_W-1:IDX_W+2];
      pred_taken_c = bus.btb_hit & ctr_q[fetch_idx_c][1];
      seq_pc_c     = bus.pc + PC_W'(4);
      npred_c      = pred_taken_c ? bus.pred_pc : seq_pc_c;
      btb_evt_c    = bus.ex_valid & bus.ex_taken;

      ctr_nxt_c = ctr_q[ex_idx_c];
      if (bus.ex_taken) begin
         if (ctr_q[ex_idx_c] != 2'b11) ctr_nxt_c = ctr_q[ex_idx_c] + 2'd1;
      end else begin
         if (ctr_q[ex_idx_c] != 2'b00) ctr_nxt_c = ctr_q[ex_idx_c] - 2'd1;
      end
   end

   // ex_pc byte offset never selects a counter or BTB tag
   assign unused_ok_c = ^bus.ex_pc[1:0];

   // Fetch PC: redirect wins over stall
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.pc <= RESET_PC;
      end else if (bus.redirect) begin
         bus.pc <= bus.redirect_pc;
      end else if (!bus.stall) begin
         bus.pc <= npred_c;
      end
   end

   // IF/ID register: a redirect squashes the entry and leaves the payload as-is
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.if_valid      <= 1'b0;
         bus.if_pc         <= '0;
         bus.if_pred_taken <= 1'b0;
         bus.if_pred_pc    <= '0;
      end else if (bus.redirect) begin
         bus.if_valid      <= 1'b0;
      end else if (!bus.stall) begin
         bus.if_valid      <= 1'b1;
         bus.if_pc         <= bus.pc;
         bus.if_pred_taken <= pred_taken_c;
         bus.if_pred_pc    <= npred_c;
      end
   end

   // BTB write command: one pulse per taken resolution, address/data held between writes
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.btb_we    <= 1'b0;
         bus.btb_waddr <= '0;
         bus.btb_wd    <= '0;
      end else begin
         bus.btb_we <= btb_evt_c;
         if (btb_evt_c) begin
            bus.btb_waddr <= ex_idx_c;
            bus.btb_wd    <= WD_W'({1'b1, ex_tag_c, bus.ex_target});
         end
      end
   end

   // Bimodal counters: updated on every resolution regardless of stall/redirect
   always_ff @(posedge clk) begin
      if (rst) begin
         ctr_q <= '{default: 2'b01};
      end else if (bus.ex_valid) begin
         ctr_q[ex_idx_c] <= ctr_nxt_c;
      end
   end
endmodule

// File: tb/tb_fetch_pc_gen.sv
// Self-checking bench for fetch_pc_gen: a behavioural model pushes the expected
// post-edge state for every driven cycle into a scoreboard queue; each test task
// pops and compares after the edge, plus spot checks of specific values.
module tb_fetch_pc_gen;
   localparam int unsigned PC_W  = 17;
   localparam int unsigned IDX_W = 5;
   localparam int unsigned WD_W  = PC_W + PC_W - IDX_W - 1;

   typedef struct packed {
      logic [PC_W-1:0]  pc;
      logic             v;
      logic [PC_W-1:0]  if_pc;
      logic             pt;
      logic [PC_W-1:0]  ppc;
      logic             we;
      logic [IDX_W-1:0] waddr;
      logic [WD_W-1:0]  wd;
   } obs_t;

   typedef struct packed {
      obs_t val;
      obs_t mask;
   } exp_t;

   typedef struct packed {
      logic            rst;
      logic            stall;
      logic            redirect;
      logic [PC_W-1:0] rpc;
      logic            exv;
      logic [PC_W-1:0] expc;
      logic            ext;
      logic [PC_W-1:0] extgt;
      logic            hit;
      logic [PC_W-1:0] ppc;
   } stim_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fetch_pc_gen_if #(.PC_W(PC_W), .IDX_W(IDX_W)) bus ();

   fetch_pc_gen #(.PC_W(PC_W), .IDX_W(IDX_W), .RESET_PC(17'h0)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   exp_t sb_q[$];

   // reference model state
   obs_t       m;
   logic [1:0] m_ctr [32];
   logic       m_if_dc;

   function automatic stim_t s_idle();
      stim_t s;
      s = '0;
      return s;
   endfunction

   function automatic stim_t s_rst();
      stim_t s;
      s = '0;
      s.rst = 1'b1;
      return s;
   endfunction

   function automatic stim_t s_stall();
      stim_t s;
      s = '0;
      s.stall = 1'b1;
      return s;
   endfunction

   function automatic stim_t s_redir(input logic [PC_W-1:0] p);
      stim_t s;
      s = '0;
      s.redirect = 1'b1;
      s.rpc = p;
      return s;
   endfunction

   function automatic stim_t s_ex(input logic [PC_W-1:0] p, input logic t, input logic [PC_W-1:0] tg);
      stim_t s;
      s = '0;
      s.exv = 1'b1;
      s.expc = p;
      s.ext = t;
      s.extgt = tg;
      return s;
   endfunction

   function automatic stim_t s_hit(input logic [PC_W-1:0] p);
      stim_t s;
      s = '0;
      s.hit = 1'b1;
      s.ppc = p;
      return s;
   endfunction

   task automatic apply(input stim_t s);
      rst             = s.rst;
      bus.stall       = s.stall;
      bus.redirect    = s.redirect;
      bus.redirect_pc = s.rpc;
      bus.ex_valid    = s.exv;
      bus.ex_pc       = s.expc;
      bus.ex_taken    = s.ext;
      bus.ex_target   = s.extgt;
      bus.btb_hit     = s.hit;
      bus.pred_pc     = s.ppc;
   endtask

   function automatic obs_t observe();
      obs_t o;
      o.pc    = bus.pc;
      o.v     = bus.if_valid;
      o.if_pc = bus.if_pc;
      o.pt    = bus.if_pred_taken;
      o.ppc   = bus.if_pred_pc;
      o.we    = bus.btb_we;
      o.waddr = bus.btb_waddr;
      o.wd    = bus.btb_wd;
      return o;
   endfunction

   // Model the effect of the currently driven inputs and queue the expectation
   task automatic predict();
      exp_t             e;
      logic [IDX_W-1:0] fi;
      logic [IDX_W-1:0] xi;
      logic             pt;
      logic [PC_W-1:0]  np;
      fi = m.pc[IDX_W+1:2];
      xi = bus.ex_pc[IDX_W+1:2];
      pt = bus.btb_hit & m_ctr[fi][1];
      np = pt ? bus.pred_pc : m.pc + PC_W'(4);
      if (rst) begin
         m = '0;
         m_if_dc = 1'b0;
         for (int i = 0; i < 32; i++) m_ctr[i] = 2'b01;
      end else begin
         if (bus.redirect) begin
            m.v = 1'b0;
            m_if_dc = 1'b1;
         end else if (!bus.stall) begin
            m.v = 1'b1;
            m.if_pc = m.pc;
            m.pt = pt;
            m.ppc = np;
            m_if_dc = 1'b0;
         end
         if (bus.redirect) m.pc = bus.redirect_pc;
         else if (!bus.stall) m.pc = np;
         m.we = bus.ex_valid & bus.ex_taken;
         if (m.we) begin
            m.waddr = xi;
            m.wd = {1'b1, bus.ex_pc[PC_W-1:IDX_W+2], bus.ex_target};
         end
         if (bus.ex_valid) begin
            if (bus.ex_taken && m_ctr[xi] != 2'b11) m_ctr[xi] = m_ctr[xi] + 2'd1;
            else if (!bus.ex_taken && m_ctr[xi] != 2'b00) m_ctr[xi] = m_ctr[xi] - 2'd1;
         end
      end
      e.val = m;
      e.mask = '1;
      if (m_if_dc) begin
         e.mask.if_pc = '0;
         e.mask.pt = 1'b0;
         e.mask.ppc = '0;
      end
      if (!m.we && !rst) begin
         e.mask.waddr = '0;
         e.mask.wd = '0;
      end
      sb_q.push_back(e);
   endtask

   task automatic cycle();
      predict();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic test_reset();
      stim_t q[$];
      exp_t  e;
      obs_t  o;
      q.push_back(s_rst() | s_ex(17'h1F4, 1'b1, 17'h80));
      q.push_back(s_rst());
      foreach (q[i]) begin
         apply(q[i]); cycle();
         e = sb_q.pop_front(); o = observe(); checks++;
         if (((o ^ e.val) & e.mask) !== '0) begin errors++; $display("FAIL reset_sb step=%0d got=%h want=%h mask=%h", i, o, e.val, e.mask); end
      end
      q.delete();
      checks++; if (bus.pc !== 17'h0) begin errors++; $display("FAIL reset_pc got=%h want=%h", bus.pc, 17'h0); end
      checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL reset_if_valid got=%b want=0", bus.if_valid); end
      checks++; if (bus.btb_we !== 1'b0) begin errors++; $display("FAIL reset_btb_we got=%b want=0", bus.btb_we); end
      q.push_back(s_idle());
      foreach (q[i]) begin
         apply(q[i]); cycle();
         e = sb_q.pop_front(); o = observe(); checks++;
         if (((o ^ e.val) & e.mask) !== '0) begin errors++; $display("FAIL run_first_sb step=%0d got=%h want=%h mask=%h", i, o, e.val, e.mask); end
      end
      q.delete();
      checks++; if (bus.pc !== 17'h4) begin errors++; $display("FAIL first_pc got=%h want=%h", bus.pc, 17'h4); end
      checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 17'h0) begin errors++; $display("FAIL first_if got=%b/%h want=1/0", bus.if_valid, bus.if_pc); end
      q.push_back(s_idle());
      q.push_back(s_idle());
      foreach (q[i]) begin
         apply(q[i]); cycle();
         e = sb_q.pop_front(); o = observe(); checks++;
         if (((o ^ e.val) & e.mask) !== '0) begin errors++; $display("FAIL run_seq_sb step=%0d got=%h want=%h mask=%h", i, o, e.val, e.mask); end
      end
      q.delete();
      checks++; if (bus.pc !== 17'hC || bus.if_pc !== 17'h8) begin errors++; $display("FAIL seq_pc got=%h/%h want=c/8", bus.pc, bus.if_pc); end
   endtask

   task automatic test_predict();
      stim_t q[$];
      exp_t  e;
      obs_t  o;
      q.push_back(s_redir(17'h10));
      q.push_back(s_hit(17'h100));
      foreach (q[i]) begin
         apply(q[i]); cycle();
         e = sb_q.pop_front(); o = observe(); checks++;
         if (((o ^ e.val) & e.mask) !== '0) begin errors++; $display("FAIL weak_sb step=%0d got=%h want=%h mask=%h", i, o, e.val, e.mask); end
      end
      q.delete();
      checks++; if (bus.pc !== 17'h14 || bus.if_pred_taken !== 1'b0) begin errors++; $display("FAIL weak_hit got=%h/%b want=14/0", bus.pc, bus.if_pred_taken); end
      q.push_back(s_ex(17'h10, 1'b1, 17'h100));
      q.push_back(s_ex(17'h10, 1'b1, 17'h100));
      q.push_back(s_redir(17'h10));
      q.push_back(s_hit(17'h100));
      foreach (q[i]) begin
         apply(q[i]); cycle();
         e = sb_q.pop_front(); o = observe(); checks++;
         if (((o ^ e.val) & e.mask) !== '0) begin errors++; $display("FAIL train_sb step=%0d got=%h want=%h mask=%h", i, o, e.val, e.mask); end
      end
      q.delete();
      checks++; if (bus.pc !== 17'h100 || bus.if_pred_taken !== 1'b1 || bus.if_pred_pc !== 17'h100) begin
         errors++; $display("FAIL strong_hit got=%h/%b/%h want=100/1/100", bus.pc, bus.if_pred_taken, bus.if_pred_pc);
      end
      q.push_back(s_ex(17'h10, 1'b1, 17'h100));
      q.push_back(s_ex(17'h10, 1'b0, 17'h0));
      q.push_back(s_redir(17'h10));
      q.push_back(s_hit(17'h100));
      foreach (q[i]) begin
         apply(q[i]); cycle();
         e = sb_q.pop_front(); o = observe(); checks++;
         if (((o ^ e.val) & e.mask) !== '0) begin errors++; $display("FAIL sat_hi_sb step=%0d got=%h want=%h mask=%h", i, o, e.val, e.mask); end
      end
      q.delete();
      checks++; if (bus.pc !== 17'h100 || bus.if_pred_taken !== 1'b1) begin errors++; $display("FAIL sat_hi got=%h/%b want=100/1", bus.pc, bus.if_pred_taken); end
   endtask

   task automatic test_not_taken();
      stim_t q[$];
      exp_t  e;
      obs_t  o;
      q.push_back(s_ex(17'h10, 1'b0, 17'h0));
      q.push_back(s_ex(17'h10, 1'b0, 17'h0));
      q.push_back(s_ex(17'h10, 1'b0, 17'h0));
      foreach (q[i]) begin
         apply(q[i]); cycle();
         e = sb_q.pop_front(); o = observe(); checks++;
         if (((o ^ e.val) & e.mask) !== '0) begin errors++; $display("FAIL nt_sb step=%0d got=%h want=%h mask=%h", i, o, e.val, e.mask); end
      end
      q.delete();
      checks++; if (bus.btb_we !== 1'b0) begin errors++; $display("FAIL nt_btb_we got=%b want=0", bus.btb_we); end
      q.push_back(s_idle());
      q.push_back(s_redir(17'h10));
      q.push_back(s_hit(17'h100));
      foreach (q[i]) begin
         apply(q[i]); cycle();
         e = sb_q.pop_front(); o = observe(); checks++;
         if (((o ^ e.val) & e.mask) !== '0) begin errors++; $display("FAIL sat_lo_sb step=%0d got=%h want=%h mask=%h", i, o, e.val, e.mask); end
      end
      q.delete();
      checks++; if (bus.pc !== 17'h14 || bus.if_pred_taken !== 1'b0) begin errors++; $display("FAIL sat_lo got=%h/%b want=14/0", bus.pc, bus.if_pred_taken); end
      q.push_back(s_ex(17'h10, 1'b1, 17'h100));
      q.push_back(s_redir(17'h10));
      q.push_back(s_hit(17'h100));
      foreach (q[i]) begin
         apply(q[i]); cycle();
         e = sb_q.pop_front(); o = observe(); checks++;
         if (((o ^ e.val) & e.mask) !== '0) begin errors++; $display("FAIL from_zero_sb step=%0d got=%h want=%h mask=%h", i, o, e.val, e.mask); end
      end
      q.delete();
      checks++; if (bus.if_pred_taken !== 1'b0) begin errors++; $display("FAIL from_zero got=%b want=0", bus.if_pred_taken); end
   endtask

   task automatic test_stall();
      stim_t q[$];
      exp_t  e;
      obs_t  o;
      q.push_back(s_stall() | s_hit(17'h300));
      q.push_back(s_stall());
      q.push_back(s_stall());
      foreach (q[i]) begin
         apply(q[i]); cycle();
         e = sb_q.pop_front(); o = observe(); checks++;
         if (((o ^ e.val) & e.mask) !== '0) begin errors++; $display("FAIL stall_sb step=%0d got=%h want=%h mask=%h", i, o, e.val, e.mask); end
      end
      q.delete();
      checks++; if (bus.pc !== 17'h14 || bus.if_pc !== 17'h10 || bus.if_valid !== 1'b1) begin
         errors++; $display("FAIL stall_hold got=%h/%h/%b want=14/10/1", bus.pc, bus.if_pc, bus.if_valid);
      end
      q.push_back(s_stall() | s_redir(17'h200));
      foreach (q[i]) begin
         apply(q[i]); cycle();
         e = sb_q.pop_front(); o = observe(); checks++;
         if (((o ^ e.val) & e.mask) !== '0) begin errors++; $display("FAIL stall_redir_sb step=%0d got=%h want=%h mask=%h", i, o, e.val, e.mask); end
      end
      q.delete();
      checks++; if (bus.pc !== 17'h200 || bus.if_valid !== 1'b0) begin errors++; $display("FAIL stall_redir got=%h/%b want=200/0", bus.pc, bus.if_valid); end
      q.push_back(s_idle());
      foreach (q[i]) begin
         apply(q[i]); cycle();
         e = sb_q.pop_front(); o = observe(); checks++;
         if (((o ^ e.val) & e.mask) !== '0) begin errors++; $display("FAIL resume_sb step=%0d got=%h want=%h mask=%h", i, o, e.val, e.mask); end
      end
      q.delete();
      checks++; if (bus.pc !== 17'h204 || bus.if_valid !== 1'b1 || bus.if_pc !== 17'h200) begin
         errors++; $display("FAIL resume got=%h/%b/%h want=204/1/200", bus.pc, bus.if_valid, bus.if_pc);
      end
   endtask

   task automatic test_btb_write();
      stim_t q[$];
      exp_t  e;
      obs_t  o;
      q.push_back(s_ex(17'h1F4, 1'b1, 17'h80));
      foreach (q[i]) begin
         apply(q[i]); cycle();
         e = sb_q.pop_front(); o = observe(); checks++;
         if (((o ^ e.val) & e.mask) !== '0) begin errors++; $display("FAIL btb_sb step=%0d got=%h want=%h mask=%h", i, o, e.val, e.mask); end
      end
      q.delete();
      checks++; if (bus.btb_we !== 1'b1 || bus.btb_waddr !== 5'h1D || bus.btb_wd !== 28'h8060080) begin
         errors++; $display("FAIL btb_cmd got=%b/%h/%h want=1/1d/8060080", bus.btb_we, bus.btb_waddr, bus.btb_wd);
      end
      q.push_back(s_idle());
      foreach (q[i]) begin
         apply(q[i]); cycle();
         e = sb_q.pop_front(); o = observe(); checks++;
         if (((o ^ e.val) & e.mask) !== '0) begin errors++; $display("FAIL btb_drop_sb step=%0d got=%h want=%h mask=%h", i, o, e.val, e.mask); end
      end
      q.delete();
      checks++; if (bus.btb_we !== 1'b0) begin errors++; $display("FAIL btb_pulse got=%b want=0", bus.btb_we); end
      // back-to-back events, one under stall and one under redirect
      q.push_back(s_ex(17'h20, 1'b1, 17'h40) | s_stall());
      q.push_back(s_ex(17'h1FF24, 1'b1, 17'h1FFFC) | s_redir(17'h400));
      q.push_back(s_idle());
      foreach (q[i]) begin
         apply(q[i]); cycle();
         e = sb_q.pop_front(); o = observe(); checks++;
         if (((o ^ e.val) & e.mask) !== '0) begin errors++; $display("FAIL b2b_sb step=%0d got=%h want=%h mask=%h", i, o, e.val, e.mask); end
      end
      q.delete();
   endtask

   task automatic test_wrap_reset();
      stim_t q[$];
      exp_t  e;
      obs_t  o;
      q.push_back(s_redir(17'h1FFFC));
      q.push_back(s_idle());
      foreach (q[i]) begin
         apply(q[i]); cycle();
         e = sb_q.pop_front(); o = observe(); checks++;
         if (((o ^ e.val) & e.mask) !== '0) begin errors++; $display("FAIL wrap_sb step=%0d got=%h want=%h mask=%h", i, o, e.val, e.mask); end
      end
      q.delete();
      checks++; if (bus.pc !== 17'h0 || bus.if_pred_pc !== 17'h0) begin errors++; $display("FAIL wrap_pc got=%h/%h want=0/0", bus.pc, bus.if_pred_pc); end
      q.push_back(s_ex(17'h10, 1'b1, 17'h100));
      q.push_back(s_ex(17'h10, 1'b1, 17'h100));
      q.push_back(s_rst() | s_ex(17'h1F4, 1'b1, 17'h80));
      foreach (q[i]) begin
         apply(q[i]); cycle();
         e = sb_q.pop_front(); o = observe(); checks++;
         if (((o ^ e.val) & e.mask) !== '0) begin errors++; $display("FAIL mid_rst_sb step=%0d got=%h want=%h mask=%h", i, o, e.val, e.mask); end
      end
      q.delete();
      checks++; if (bus.btb_we !== 1'b0 || bus.pc !== 17'h0) begin errors++; $display("FAIL mid_rst got=%b/%h want=0/0", bus.btb_we, bus.pc); end
      q.push_back(s_redir(17'h10));
      q.push_back(s_hit(17'h100));
      foreach (q[i]) begin
         apply(q[i]); cycle();
         e = sb_q.pop_front(); o = observe(); checks++;
         if (((o ^ e.val) & e.mask) !== '0) begin errors++; $display("FAIL ctr_init_sb step=%0d got=%h want=%h mask=%h", i, o, e.val, e.mask); end
      end
      q.delete();
      checks++; if (bus.pc !== 17'h14 || bus.if_pred_taken !== 1'b0) begin errors++; $display("FAIL ctr_init got=%h/%b want=14/0", bus.pc, bus.if_pred_taken); end
   endtask

   initial begin
      apply(s_rst());
      test_reset();
      test_predict();
      test_not_taken();
      test_stall();
      test_btb_write();
      test_wrap_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
